// File: rtl/led_pkg.sv
// Shared mode encodings for the LED sampler and its bus interface.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DIRECT = 2'b00;
  localparam mode_t MODE_HOLD   = 2'b01;
  localparam mode_t MODE_BLINK  = 2'b10;
  localparam mode_t MODE_CHASE  = 2'b11;

endpackage

// File: rtl/led_sampler_multimode_if.sv
// Control/display bundle between the decoder side (master) and the LED sampler (slave).
interface led_sampler_multimode_if
  import led_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] led;
  logic             tick;
  logic             changed;

  modport master (
    output en, mode, bin,
    input  led, tick, changed
  );

  modport slave (
    input  en, mode, bin,
    output led, tick, changed
  );

endinterface

// File: rtl/led_sampler_multimode_tick_gen.sv
// Free-running sampling divider: strobes combinationally on the last count of each period.
module tick_gen #(
  parameter int TICK_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sample_stb
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  generate
    if (TICK_CYCLES < 2) begin : g_bad_tick_cycles
      $error("tick_gen: TICK_CYCLES must be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_reg;

  assign sample_stb = en && (cnt_reg == CNT_LAST);

  // Disabling freezes the count so the current period resumes where it left off.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (sample_stb) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_sampler_multimode.sv
// LED driver: samples bin on a divided tick and shows it in direct, hold, blink or chase mode.
module led_sampler_multimode
  import led_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int TICK_CYCLES = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  led_sampler_multimode_if.slave bus
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("led_sampler_multimode: WIDTH must be >= 1");
    end
  endgenerate

  logic             sample_stb;
  logic [WIDTH-1:0] sample_reg;
  logic [WIDTH-1:0] chase_reg;
  logic [WIDTH-1:0] chase_rot;
  logic [WIDTH-1:0] chase_next;
  logic [WIDTH-1:0] led_reg;
  logic [WIDTH-1:0] led_next;
  logic             phase_reg;
  logic             phase_next;
  logic             tick_reg;
  logic             changed_reg;
  mode_t            mode_reg;
  logic             enter_blink;
  logic             enter_chase;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .sample_stb(sample_stb)
  );

  // Rotate left by one with MSB wrapping to LSB; a single LED maps onto itself.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
    assign chase_rot[gi] = chase_reg[(gi + WIDTH - 1) % WIDTH];
  end

  always_comb begin
    enter_blink = (bus.mode == MODE_BLINK) && (mode_reg != MODE_BLINK);
    enter_chase = (bus.mode == MODE_CHASE) && (mode_reg != MODE_CHASE);

    // A mode-entry load wins over the tick-driven toggle/rotate in the same edge.
    phase_next = phase_reg;
    if (enter_blink) begin
      phase_next = 1'b1;
    end else if (sample_stb) begin
      phase_next = ~phase_reg;
    end

    chase_next = chase_reg;
    if (enter_chase) begin
      chase_next = WIDTH'(1);
    end else if (sample_stb) begin
      chase_next = chase_rot;
    end

    led_next = bus.bin;
    case (bus.mode)
      MODE_DIRECT: led_next = bus.bin;
      MODE_HOLD:   led_next = sample_reg;
      MODE_BLINK:  led_next = phase_reg ? sample_reg : '0;
      MODE_CHASE:  led_next = chase_reg;
      default:     led_next = bus.bin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg  <= '0;
      phase_reg   <= 1'b1;
      chase_reg   <= WIDTH'(1);
      led_reg     <= '0;
      tick_reg    <= 1'b0;
      changed_reg <= 1'b0;
      mode_reg    <= MODE_DIRECT;
    end else begin
      tick_reg    <= sample_stb;
      changed_reg <= sample_stb && (bus.bin != sample_reg);
      if (sample_stb) begin
        sample_reg <= bus.bin;
      end
      phase_reg <= phase_next;
      chase_reg <= chase_next;
      led_reg   <= led_next;
      mode_reg  <= bus.mode;
    end
  end

  assign bus.led     = led_reg;
  assign bus.tick    = tick_reg;
  assign bus.changed = changed_reg;

endmodule

// File: tb/tb_led_sampler_multimode.sv
// Scenario bench for led_sampler_multimode (WIDTH=4/TICK_CYCLES=4 plus a WIDTH=1/TICK_CYCLES=2 instance).
module tb_led_sampler_multimode;
  import led_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  typedef struct {
    logic       chk_led;
    logic [3:0] led;
    logic       tick;
    logic       changed;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  led_sampler_multimode_if #(.WIDTH(4)) bus ();
  led_sampler_multimode_if #(.WIDTH(1)) bus1 ();

  led_sampler_multimode #(
    .WIDTH      (4),
    .TICK_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  led_sampler_multimode #(
    .WIDTH      (1),
    .TICK_CYCLES(2)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en_v, input mode_t mode_v, input logic [3:0] bin_v);
    bus.en   = en_v;
    bus.mode = mode_v;
    bus.bin  = bin_v;
    reset    = 1'b1;
    tick_clk();
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, MODE_DIRECT, 4'b1111);
    tick_clk();
    tick_clk();
    n_tests++;
    if (bus.led !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_pre_direct: led=%b, expected 1111", bus.led);
    end
    reset = 1'b1;
    tick_clk();
    n_tests++;
    if (bus.led !== 4'b0000 || bus.tick !== 1'b0 || bus.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: led=%b tick=%b changed=%b, expected 0000 0 0",
               bus.led, bus.tick, bus.changed);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_hold();
    logic [3:0]  led_t [12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'hA,
                                4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    logic [11:0] tick_m = 12'b1000_1000_1000;
    logic [11:0] ch_m   = 12'b0000_0000_1000;
    exp_t e;
    do_reset(1'b1, MODE_HOLD, 4'b1010);
    for (int i = 0; i < 12; i++) begin
      sb_q.push_back('{1'b1, led_t[i], tick_m[i], ch_m[i], i + 1});
      tick_clk();
      e = sb_q.pop_front();
      n_tests++;
      if (bus.led !== e.led || bus.tick !== e.tick || bus.changed !== e.changed) begin
        n_fail++;
        $display("FAIL hold cyc %0d: led=%b tick=%b changed=%b, expected led=%b tick=%b changed=%b",
                 e.cyc, bus.led, bus.tick, bus.changed, e.led, e.tick, e.changed);
      end
    end
    $display("[TB] test_hold done");
  endtask

  task automatic test_direct();
    logic [3:0] led_t [5] = '{4'b0000, 4'b0110, 4'b1111, 4'b0000, 4'b1111};
    logic [4:0] tick_m = 5'b01000;
    logic [4:0] ch_m   = 5'b01000;
    exp_t e;
    do_reset(1'b1, MODE_DIRECT, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.bin = 4'b0110;
      if (i == 2) bus.bin = 4'b1111;
      if (i == 3) bus.mode = MODE_HOLD;
      sb_q.push_back('{1'b1, led_t[i], tick_m[i], ch_m[i], i + 1});
      tick_clk();
      e = sb_q.pop_front();
      n_tests++;
      if (bus.led !== e.led || bus.tick !== e.tick || bus.changed !== e.changed) begin
        n_fail++;
        $display("FAIL direct cyc %0d: led=%b tick=%b changed=%b, expected led=%b tick=%b changed=%b",
                 e.cyc, bus.led, bus.tick, bus.changed, e.led, e.tick, e.changed);
      end
    end
    $display("[TB] test_direct done");
  endtask

  task automatic test_blink();
    logic [3:0]  led_t [21] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0,
                                4'h0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
    logic [20:0] tick_m = 21'b0_1000_1000_1000_1000_1000;
    logic [20:0] ch_m   = 21'b0_0000_1000_0000_0000_1000;
    exp_t e;
    do_reset(1'b1, MODE_HOLD, 4'b0101);
    for (int i = 0; i < 21; i++) begin
      if (i == 5)  bus.mode = MODE_BLINK;
      if (i == 13) bus.bin  = 4'b0011;
      sb_q.push_back('{1'b1, led_t[i], tick_m[i], ch_m[i], i + 1});
      tick_clk();
      e = sb_q.pop_front();
      n_tests++;
      if (bus.led !== e.led || bus.tick !== e.tick || bus.changed !== e.changed) begin
        n_fail++;
        $display("FAIL blink cyc %0d: led=%b tick=%b changed=%b, expected led=%b tick=%b changed=%b",
                 e.cyc, bus.led, bus.tick, bus.changed, e.led, e.tick, e.changed);
      end
    end
    $display("[TB] test_blink done");
  endtask

  task automatic test_chase();
    logic [3:0]  led_t [21] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2,
                                4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1};
    logic [20:0] tick_m = 21'b0_1000_1000_1000_1000_1000;
    logic        w1_tick_exp;
    exp_t e;
    do_reset(1'b1, MODE_DIRECT, 4'b0000);
    for (int i = 0; i < 21; i++) begin
      if (i == 5) bus.mode = MODE_CHASE;
      // The entry edge shows the chase register as it stood before the reload.
      sb_q.push_back('{(i != 5), led_t[i], tick_m[i], 1'b0, i + 1});
      tick_clk();
      e = sb_q.pop_front();
      n_tests++;
      if ((e.chk_led && bus.led !== e.led) || bus.tick !== e.tick || bus.changed !== e.changed) begin
        n_fail++;
        $display("FAIL chase cyc %0d: led=%b tick=%b changed=%b, expected led=%b tick=%b changed=%b",
                 e.cyc, bus.led, bus.tick, bus.changed, e.led, e.tick, e.changed);
      end
      w1_tick_exp = ((i + 1) % 2 == 0);
      n_tests++;
      if (bus1.led !== 1'b1 || bus1.tick !== w1_tick_exp) begin
        n_fail++;
        $display("FAIL chase_w1 cyc %0d: led=%b tick=%b, expected led=1 tick=%b",
                 i + 1, bus1.led, bus1.tick, w1_tick_exp);
      end
    end
    $display("[TB] test_chase done");
  endtask

  task automatic test_enable();
    logic [3:0]  led_t [15] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h6};
    logic [14:0] tick_m = 15'b010_0000_0000_0000;
    logic [14:0] ch_m   = 15'b010_0000_0000_0000;
    exp_t e;
    do_reset(1'b1, MODE_HOLD, 4'b0110);
    for (int i = 0; i < 15; i++) begin
      if (i == 2)  bus.en = 1'b0;
      if (i == 12) bus.en = 1'b1;
      sb_q.push_back('{1'b1, led_t[i], tick_m[i], ch_m[i], i + 1});
      tick_clk();
      e = sb_q.pop_front();
      n_tests++;
      if (bus.led !== e.led || bus.tick !== e.tick || bus.changed !== e.changed) begin
        n_fail++;
        $display("FAIL enable cyc %0d: led=%b tick=%b changed=%b, expected led=%b tick=%b changed=%b",
                 e.cyc, bus.led, bus.tick, bus.changed, e.led, e.tick, e.changed);
      end
    end
    $display("[TB] test_enable done");
  endtask

  task automatic test_reset_mid();
    logic [3:0]  led_t [15] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2,
                                4'h4, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2};
    logic [14:0] tick_m = 15'b010_0000_1000_1000;
    exp_t e;
    do_reset(1'b1, MODE_CHASE, 4'b0000);
    for (int i = 0; i < 15; i++) begin
      if (i == 9)  reset = 1'b1;
      if (i == 10) reset = 1'b0;
      sb_q.push_back('{1'b1, led_t[i], tick_m[i], 1'b0, i + 1});
      tick_clk();
      e = sb_q.pop_front();
      n_tests++;
      if (bus.led !== e.led || bus.tick !== e.tick || bus.changed !== e.changed) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: led=%b tick=%b changed=%b, expected led=%b tick=%b changed=%b",
                 e.cyc, bus.led, bus.tick, bus.changed, e.led, e.tick, e.changed);
      end
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    n_tests   = 0;
    n_fail    = 0;
    bus.en    = 1'b0;
    bus.mode  = MODE_DIRECT;
    bus.bin   = 4'b0000;
    bus1.en   = 1'b1;
    bus1.mode = MODE_CHASE;
    bus1.bin  = 1'b0;

    test_reset();
    test_hold();
    test_direct();
    test_blink();
    test_chase();
    test_enable();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
